overlay_palette_mixer: RTL and testbench

Video output stage directly downstream of the on-screen overlay generator. Each `pixel_clock` enable it merges the VDP's 4-bit colour with the overlay's 4-bit colour, maps the winning index through CPU-writable 24-bit palettes and emits registered 8-8-8 RGB. Sync is delay-matched to the pixel path. Palettes and control live on the same 32-bit big-endian MMIO bus style as the overlay.

---
 rtl/overlay_palette_mixer_if.sv | 24 ++
 rtl/overlay_palette_mixer.sv | 218 +++++++++++++++++++++
 tb/tb_overlay_palette_mixer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/overlay_palette_mixer_if.sv
// ---------------------------------------------------------------------------
// overlay_palette_mixer_if
// 32-bit big-endian MMIO bus used by the overlay palette mixer.
//   adr [0:5]  word address (adr[0]=0 palette entry adr[1:5], adr[0]=1 CTRL)
//   cs         bus cycle strobe
//   sel [0:3]  byte lane enables, sel[0] covers d[0:7]
//   we         write strobe
//   d   [0:31] write data
//   q   [0:31] read data (registered in the slave)
//   ack        bus acknowledge
// Modports: master drives the request, slave answers with q/ack.
// ---------------------------------------------------------------------------
interface overlay_palette_mixer_if;
  logic [0:5]  adr;
  logic        cs;
  logic [0:3]  sel;
  logic        we;
  logic [0:31] d;
  logic [0:31] q;
  logic        ack;

  modport master (output adr, cs, sel, we, d, input q, ack);
  modport slave  (input adr, cs, sel, we, d, output q, ack);
endinterface

// File: rtl/overlay_palette_mixer.sv
// ---------------------------------------------------------------------------
// overlay_palette_mixer
// Merges the VDP 4-bit colour with the overlay 4-bit colour on every
// pixel_clock enable, maps the winning index through CPU-writable 24-bit
// palettes and emits registered 8-8-8 RGB with delay-matched sync.
//
// Parameter:
//   OVL_PRIORITY  1: non-zero overlay overrides VDP; 0: overlay only where VDP=0
// Optional feature macro:
//   OVERLAY_PALETTE_BLEND_EN  overlay entries carry a blend flag (d[7]); when
//                             set the overlay is averaged with the VDP/border RGB
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   bus (slave)            palette / CTRL MMIO access
//   pixel_clock            one-clk-wide pixel enable
//   hsync_in, vsync_in     sync from the timing source
//   vdp_color, ovl_color   colour indices (ovl_color 0 = transparent)
//   hsync, vsync           sync delayed by the 3-stage pixel pipeline
//   red, green, blue       registered pixel colour
// ---------------------------------------------------------------------------
module overlay_palette_mixer #(
  parameter int OVL_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       reset,
  overlay_palette_mixer_if.slave bus,
  input  logic       pixel_clock,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [0:3] vdp_color,
  input  logic [0:3] ovl_color,
  output logic       hsync,
  output logic       vsync,
  output logic [0:7] red,
  output logic [0:7] green,
  output logic [0:7] blue
);
  localparam logic [0:31] CTRL_MASK  = 32'h0000_00F3;
  localparam logic [0:31] CTRL_RESET = 32'h0000_0001;

  function automatic logic [0:31] vdp_default(input logic [0:3] idx);
    case (idx)
      4'd2:    return 32'h0021_C842;
      4'd3:    return 32'h005E_DC78;
      4'd4:    return 32'h0054_55ED;
      4'd5:    return 32'h007D_76FC;
      4'd6:    return 32'h00D4_524D;
      4'd7:    return 32'h0042_EBF5;
      4'd8:    return 32'h00FC_5554;
      4'd9:    return 32'h00FF_7978;
      4'd10:   return 32'h00D4_C154;
      4'd11:   return 32'h00E6_CE80;
      4'd12:   return 32'h0021_B03B;
      4'd13:   return 32'h00C9_5BBA;
      4'd14:   return 32'h00CC_CCCC;
      4'd15:   return 32'h00FF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

`ifdef OVERLAY_PALETTE_BLEND_EN
  // Average of two channels: 9-bit sum, keep the upper 8 bits.
  function automatic logic [7:0] blend_chan(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction
`endif

  logic [0:31] r_pal [0:31];
  logic [0:31] r_ctrl;
  logic [0:31] r_q;
  logic        r_rd_ack;

  logic [0:4]  w_idx;
  logic [0:31] w_bmask;
  logic [0:31] w_keep;
  logic [0:31] w_rdata;

  assign w_idx   = bus.adr[1:5];
  assign w_bmask = {{8{bus.sel[0]}}, {8{bus.sel[1]}}, {8{bus.sel[2]}}, {8{bus.sel[3]}}};
`ifdef OVERLAY_PALETTE_BLEND_EN
  // Only overlay entries (16-31) keep the blend flag bit.
  assign w_keep  = w_idx[0] ? 32'h01FF_FFFF : 32'h00FF_FFFF;
`else
  assign w_keep  = 32'h00FF_FFFF;
`endif

  always_comb begin
    w_rdata = '0;
    if (!bus.adr[0])          w_rdata = r_pal[w_idx];
    else if (w_idx == 5'd0)   w_rdata = r_ctrl;
  end

  assign bus.q   = r_q;
  assign bus.ack = (bus.cs && bus.we) || r_rd_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_pal[i] <= (i < 16) ? vdp_default(4'(i)) : '0;
      r_ctrl   <= CTRL_RESET;
      r_q      <= '0;
      r_rd_ack <= 1'b0;
    end else begin
      if (bus.cs && bus.we) begin
        if (!bus.adr[0])
          r_pal[w_idx] <= (r_pal[w_idx] & ~w_bmask) | (bus.d & w_bmask & w_keep);
        else if (w_idx == 5'd0)
          r_ctrl <= (r_ctrl & ~w_bmask) | (bus.d & w_bmask & CTRL_MASK);
      end
      // The master holds cs until ack, so r_rd_ack blocks a second capture.
      r_rd_ack <= bus.cs && !bus.we && !r_rd_ack;
      if (bus.cs && !bus.we && !r_rd_ack)
        r_q <= w_rdata;
    end
  end

  logic       w_ovl_en, w_blank_ctl, w_win;
  logic [0:3] w_border;
  assign w_ovl_en    = r_ctrl[31];
  assign w_blank_ctl = r_ctrl[30];
  assign w_border    = r_ctrl[24:27];
  assign w_win       = w_ovl_en && (ovl_color != 4'd0) &&
                       ((OVL_PRIORITY != 0) || (vdp_color == 4'd0));

  // Stage 1: latch colours, syncs and winner decision
  logic       r_vld_p1, r_hs_p1, r_vs_p1, r_win_p1;
  logic [0:3] r_vdp_p1, r_ovl_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
    end else if (pixel_clock) begin
      r_vld_p1 <= 1'b1;
      r_hs_p1  <= hsync_in;
      r_vs_p1  <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_clock) begin
      r_vdp_p1 <= vdp_color;
      r_ovl_p1 <= ovl_color;
      r_win_p1 <= w_win;
    end
  end

  // Stage 2: palette lookup
  logic [0:3]  w_bg_idx;
  logic [0:4]  w_sel_idx;
  logic        r_vld_p2, r_hs_p2, r_vs_p2;
  logic [0:23] r_rgb_p2;
`ifdef OVERLAY_PALETTE_BLEND_EN
  logic [0:23] r_bg_p2;
  logic        r_mix_p2;
`endif

  assign w_bg_idx  = (r_vdp_p1 != 4'd0) ? r_vdp_p1 : w_border;
  assign w_sel_idx = r_win_p1 ? {1'b1, r_ovl_p1} : {1'b0, w_bg_idx};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2 <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
    end else if (pixel_clock) begin
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_clock) begin
      r_rgb_p2 <= r_pal[w_sel_idx][8:31];
`ifdef OVERLAY_PALETTE_BLEND_EN
      r_bg_p2  <= r_pal[{1'b0, w_bg_idx}][8:31];
      r_mix_p2 <= r_win_p1 && r_pal[w_sel_idx][7];
`endif
    end
  end

  // Stage 3: blend / blank, register outputs
  logic [0:23] w_rgb;
  logic        w_blank;

  always_comb begin
    w_rgb = r_rgb_p2;
`ifdef OVERLAY_PALETTE_BLEND_EN
    if (r_mix_p2)
      w_rgb = {blend_chan(r_rgb_p2[0:7],   r_bg_p2[0:7]),
               blend_chan(r_rgb_p2[8:15],  r_bg_p2[8:15]),
               blend_chan(r_rgb_p2[16:23], r_bg_p2[16:23])};
`endif
  end

  // Invalid slots (after reset) are shown black like blanked pixels.
  assign w_blank = !r_vld_p2 || r_hs_p2 || r_vs_p2 || w_blank_ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pixel_clock) begin
      hsync <= r_hs_p2;
      vsync <= r_vs_p2;
      red   <= w_blank ? 8'h00 : w_rgb[0:7];
      green <= w_blank ? 8'h00 : w_rgb[8:15];
      blue  <= w_blank ? 8'h00 : w_rgb[16:23];
    end
  end
endmodule

// File: tb/tb_overlay_palette_mixer.sv
// ---------------------------------------------------------------------------
// tb_overlay_palette_mixer
// Drives two mixers (OVL_PRIORITY=1 and 0) with shared pixel inputs and
// identical bus traffic. Directed table vectors and sequences cover reset,
// lookup, CTRL, sync blanking and read/write timing; random streams are
// checked against a palette/CTRL model that computes each pixel's colour
// from the mixing rules and delays it by two enables in a queue.
// ---------------------------------------------------------------------------
module tb_overlay_palette_mixer;
`ifdef OVERLAY_PALETTE_BLEND_EN
  localparam bit BLEND = 1'b1;
`else
  localparam bit BLEND = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pc, hs_in, vs_in;
  logic [0:3] vdp, ovl;
  logic       hs1, vs1, hs0, vs0;
  logic [0:7] r1, g1, b1, r0, g0, b0;

  overlay_palette_mixer_if bus1();
  overlay_palette_mixer_if bus0();

  overlay_palette_mixer #(.OVL_PRIORITY(1)) dut (
    .clk(clk), .reset(reset), .bus(bus1), .pixel_clock(pc),
    .hsync_in(hs_in), .vsync_in(vs_in), .vdp_color(vdp), .ovl_color(ovl),
    .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1));

  overlay_palette_mixer #(.OVL_PRIORITY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .pixel_clock(pc),
    .hsync_in(hs_in), .vsync_in(vs_in), .vdp_color(vdp), .ovl_color(ovl),
    .hsync(hs0), .vsync(vs0), .red(r0), .green(g0), .blue(b0));

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned defpal [16] = '{32'h000000, 32'h000000, 32'h21C842, 32'h5EDC78,
                               32'h5455ED, 32'h7D76FC, 32'hD4524D, 32'h42EBF5,
                               32'hFC5554, 32'hFF7978, 32'hD4C154, 32'hE6CE80,
                               32'h21B03B, 32'hC95BBA, 32'hCCCCCC, 32'hFFFFFF};
  int unsigned mpal [32];
  int unsigned mctrl;

  task automatic mreset();
    for (int e = 0; e < 32; e++) mpal[e] = (e < 16) ? defpal[e] : 0;
    mctrl = 1;
  endtask

  task automatic mwrite(input int a, input int s, input int unsigned dat);
    int unsigned m, keep;
    m = 0;
    for (int i = 0; i < 4; i++) if ((s >> i) & 1) m |= 32'hFF << (8 * i);
    if (a < 32) begin
      keep = (a >= 16 && BLEND) ? 32'h01FFFFFF : 32'h00FFFFFF;
      mpal[a] = (mpal[a] & ~m) | (dat & m & keep);
    end else if (a == 32) begin
      mctrl = (mctrl & ~m) | (dat & m & 32'hF3);
    end
  endtask

  function automatic int unsigned mread(input int a);
    if (a < 32) return mpal[a];
    if (a == 32) return mctrl;
    return 0;
  endfunction

  function automatic int unsigned mexp(input int prio, input int v, input int o, input int h, input int vv);
    int unsigned bg, ov, res;
    if (h != 0 || vv != 0 || ((mctrl >> 1) & 1) != 0) return 0;
    bg = mpal[(v != 0) ? v : ((mctrl >> 4) & 15)] & 32'hFFFFFF;
    if ((mctrl & 1) != 0 && o != 0 && (prio != 0 || v == 0)) begin
      ov = mpal[16 + o];
      if (BLEND && ((ov >> 24) & 1) != 0) begin
        res = 0;
        for (int c = 0; c < 3; c++)
          res |= ((((ov >> (8 * c)) & 255) + ((bg >> (8 * c)) & 255)) / 2) << (8 * c);
        return res;
      end
      return ov & 32'hFFFFFF;
    end
    return bg;
  endfunction

  typedef struct { int unsigned rgb1; int unsigned rgb0; bit hs; bit vs; } exp_t;
  exp_t eq [$];

  typedef struct { logic [3:0] v; logic [3:0] o; logic h; logic s; logic [23:0] rgb; } vec_t;
  vec_t tbl [8];

  // ---------------- bus / pixel helpers ----------------
  task automatic drive(input logic c, input logic w, input int a, input logic [3:0] s, input logic [31:0] dat);
    bus1.cs = c; bus1.we = w; bus1.adr = 6'(a); bus1.sel = s; bus1.d = dat;
    bus0.cs = c; bus0.we = w; bus0.adr = 6'(a); bus0.sel = s; bus0.d = dat;
  endtask

  task automatic bus_write(input int a, input logic [3:0] s, input logic [31:0] dat);
    @(negedge clk);
    drive(1'b1, 1'b1, a, s, dat);
    #1;
    chk("write_ack", {31'b0, bus1.ack}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 4'h0, 32'h0);
    mwrite(a, int'(s), dat);
  endtask

  task automatic bus_read(input int a, output logic [31:0] val, output int lat, output logic ack_after);
    @(negedge clk);
    drive(1'b1, 1'b0, a, 4'h0, 32'h0);
    lat = 0;
    val = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus1.ack) begin
        lat = i;
        val = bus1.q;
        break;
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    ack_after = bus1.ack;
  endtask

  task automatic read_chk(input string name, input int a, input logic [31:0] exp);
    logic [31:0] v;
    int lat;
    logic aa;
    bus_read(a, v, lat, aa);
    chk({name, "_q"}, v, exp);
    chk({name, "_lat"}, lat, 32'd1);
    chk({name, "_ack_drop"}, {31'b0, aa}, 32'd0);
  endtask

  task automatic pix(input int gap);
    @(negedge clk);
    pc = 1'b1;
    @(negedge clk);
    pc = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic set_px(input int v, input int o, input logic h, input logic s);
    vdp = 4'(v); ovl = 4'(o); hs_in = h; vs_in = s;
  endtask

  task automatic stream(input int n);
    exp_t e;
    eq.delete();
    for (int k = 0; k < n; k++) begin
      set_px(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
             ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      e.rgb1 = mexp(1, int'(vdp), int'(ovl), int'(hs_in), int'(vs_in));
      e.rgb0 = mexp(0, int'(vdp), int'(ovl), int'(hs_in), int'(vs_in));
      e.hs   = hs_in;
      e.vs   = vs_in;
      eq.push_back(e);
      pix($urandom_range(0, 3));
      if (eq.size() == 3) begin
        e = eq.pop_front();
        chk("rand_rgb_prio1", {8'h00, r1, g1, b1}, e.rgb1);
        chk("rand_rgb_prio0", {8'h00, r0, g0, b0}, e.rgb0);
        chk("rand_sync", 32'({hs1, vs1, hs0, vs0}), 32'({e.hs, e.vs, e.hs, e.vs}));
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{4'd2,  4'd0, 1'b0, 1'b0, 24'h21C842};
    tbl[1] = '{4'd5,  4'd0, 1'b0, 1'b0, 24'h7D76FC};
    tbl[2] = '{4'd15, 4'd0, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[3] = '{4'd0,  4'd0, 1'b0, 1'b0, 24'h000000};
    tbl[4] = '{4'd9,  4'd3, 1'b0, 1'b0, 24'h000000};
    tbl[5] = '{4'd12, 4'd0, 1'b1, 1'b0, 24'h000000};
    tbl[6] = '{4'd7,  4'd0, 1'b0, 1'b1, 24'h000000};
    tbl[7] = '{4'd13, 4'd0, 1'b0, 1'b0, 24'hC95BBA};

    reset = 1'b1;
    pc = 1'b0;
    set_px(0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 4'h0, 32'h0);
    mreset();
    repeat (3) @(negedge clk);
    chk("reset_rgb", {8'h00, r1, g1, b1}, 32'h0);
    chk("reset_sync", 32'({hs1, vs1}), 32'h0);
    chk("reset_q", bus1.q, 32'h0);
    chk("reset_ack", {31'b0, bus1.ack}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First valid pixel appears after the third enable.
    set_px(2, 0, 1'b0, 1'b0);
    pix(2); pix(2);
    chk("startup_black", {8'h00, r1, g1, b1}, 32'h0);
    pix(2);
    chk("startup_rgb", {8'h00, r1, g1, b1}, 32'h21C842);
    chk("startup_sync", 32'({hs1, vs1}), 32'h0);

    for (int i = 0; i < 8; i++) begin
      set_px(int'(tbl[i].v), int'(tbl[i].o), tbl[i].h, tbl[i].s);
      pix(2); pix(2); pix(2);
      chk($sformatf("tbl%0d_rgb", i), {8'h00, r1, g1, b1}, {8'h00, tbl[i].rgb});
      chk($sformatf("tbl%0d_sync", i), 32'({hs1, vs1}), 32'({tbl[i].h, tbl[i].s}));
    end

    // Overlay entry 17 wins over VDP 15 only with priority.
    bus_write(17, 4'hF, 32'h00FF8000);
    set_px(15, 1, 1'b0, 1'b0);
    pix(2); pix(2); pix(2);
    chk("ovl17_prio1", {8'h00, r1, g1, b1}, 32'hFF8000);
    chk("ovl17_prio0", {8'h00, r0, g0, b0}, 32'hFFFFFF);
    read_chk("rd17", 17, 32'h00FF8000);

    // OVL_EN cleared via the low byte lane.
    bus_write(32, 4'b0001, 32'h00000000);
    pix(2); pix(2); pix(2);
    chk("ovl_disabled", {8'h00, r1, g1, b1}, 32'hFFFFFF);
    read_chk("rd_ctrl0", 32, 32'h0);

    // Border colour plus a single-enable hsync pulse.
    bus_write(32, 4'hF, 32'hFFFFFF41);
    read_chk("rd_ctrl", 32, 32'h00000041);
    set_px(0, 0, 1'b0, 1'b0);
    pix(2); pix(2); pix(2);
    chk("border_rgb", {8'h00, r1, g1, b1}, 32'h5455ED);
    hs_in = 1'b1;
    pix(2);
    hs_in = 1'b0;
    chk("hs_pulse_e0", {23'b0, hs1, r1, g1, b1}, 32'h005455ED);
    pix(2);
    chk("hs_pulse_e1", {23'b0, hs1, r1, g1, b1}, 32'h005455ED);
    pix(2);
    chk("hs_pulse_e2", {23'b0, hs1, r1, g1, b1}, 32'h01000000);
    pix(2);
    chk("hs_pulse_e3", {23'b0, hs1, r1, g1, b1}, 32'h005455ED);

    // BLANK forces black.
    bus_write(32, 4'hF, 32'h00000003);
    pix(2); pix(2); pix(2);
    chk("blank_ctrl", {8'h00, r1, g1, b1}, 32'h0);
    bus_write(32, 4'hF, 32'h00000001);

    // Palette write in the same clk as the lookup of that entry.
    set_px(2, 0, 1'b0, 1'b0);
    pix(2); pix(2); pix(2);
    pix(2);
    @(negedge clk);
    pc = 1'b1;
    drive(1'b1, 1'b1, 2, 4'hF, 32'h00123456);
    @(negedge clk);
    pc = 1'b0;
    drive(1'b0, 1'b0, 0, 4'h0, 32'h0);
    mwrite(2, 15, 32'h00123456);
    repeat (2) @(negedge clk);
    pix(2);
    chk("wr_lookup_old", {8'h00, r1, g1, b1}, 32'h21C842);
    pix(2);
    chk("wr_lookup_new", {8'h00, r1, g1, b1}, 32'h123456);
    bus_write(2, 4'hF, 32'h0021C842);

    // Blend flag on overlay entry 17.
    bus_write(17, 4'hF, 32'h01FF0000);
    set_px(15, 1, 1'b0, 1'b0);
    pix(2); pix(2); pix(2);
    chk("blend_rgb", {8'h00, r1, g1, b1}, BLEND ? 32'hFF7F7F : 32'hFF0000);
    read_chk("rd17_flag", 17, BLEND ? 32'h01FF0000 : 32'h00FF0000);

    // Mid-frame reset clears the pipeline and the palettes.
    set_px(2, 0, 1'b0, 1'b0);
    pix(2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mreset();
    chk("midreset_rgb", {8'h00, r1, g1, b1}, 32'h0);
    read_chk("midreset_pal17", 17, 32'h0);
    read_chk("midreset_ctrl", 32, 32'h1);
    pix(2); pix(2);
    chk("midreset_black", {8'h00, r1, g1, b1}, 32'h0);
    pix(2);
    chk("midreset_rgb3", {8'h00, r1, g1, b1}, 32'h21C842);

    // Random palettes / CTRL, random pixel streams.
    for (int round = 0; round < 4; round++) begin
      int unsigned cd;
      for (int j = 0; j < 12; j++)
        bus_write($urandom_range(0, 31), ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)), $urandom);
      cd = $urandom;
      if (round != 3) cd &= ~32'h2;
      bus_write(32, 4'hF, cd);
      for (int j = 0; j < 4; j++) begin
        int a;
        a = $urandom_range(0, 63);
        read_chk("rand_rd", a, mread(a));
      end
      stream(30);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
